// File: rtl/rule110_pkg.sv
// Shared types and sizes for the Rule 110 run controller.
package rule110_pkg;

    localparam int RULE110_W     = 512;
    localparam int RULE110_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEED = 2'd1,
        RUN  = 2'd2,
        OUT  = 2'd3
    } state_t;

endpackage

// File: rtl/rule110_gen_counter.sv
// Generation counter: captures the target on clear, counts RUN cycles and
// flags the final RUN cycle.
module rule110_gen_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clear_i,
    input  logic [CNT_W-1:0] tgt_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             last_o,
    output logic             tgt_zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] tgt_q;

    // Counter and captured target.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
            tgt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
            tgt_q <= tgt_i;
        end else if (inc_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    // The FSM leaves RUN on the cycle last_o is high, so cnt_q never wraps.
    assign last_o     = (cnt_q == (tgt_q - CNT_W'(1)));
    assign tgt_zero_o = (tgt_q == '0);
    assign cnt_o      = cnt_q;

endmodule

// File: rtl/rule110_sequencer.sv
// Run controller for the Rule 110 engine: seed, step N generations, freeze, present result.
// Optional fixed-point early exit is enabled by defining RULE110_STEADY_DETECT_EN.
module rule110_sequencer
    import rule110_pkg::*;
#(
    parameter int W     = RULE110_W,
    parameter int CNT_W = RULE110_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [W-1:0]     seed,
    input  logic [CNT_W-1:0] gen_count,
    output logic             engine_load,
    output logic [W-1:0]     engine_data,
    input  logic [W-1:0]     engine_q,
    output logic             busy,
    output logic [W-1:0]     result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [CNT_W-1:0] gens_run,
    output logic             steady,
    output logic             done,
    output logic             aborted
);

    state_t       state_q, state_d;
    logic [W-1:0] seed_q, seed_d;
    logic         done_q, done_d;
    logic         aborted_q, aborted_d;
    logic         cnt_clear_s, cnt_last_s, tgt_zero_s, early_s;

    rule110_gen_counter #(.CNT_W(CNT_W)) u_counter (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .clear_i    (cnt_clear_s),
        .tgt_i      (gen_count),
        .inc_i      (state_q == RUN),
        .cnt_o      (gens_run),
        .last_o     (cnt_last_s),
        .tgt_zero_o (tgt_zero_s)
    );

`ifdef RULE110_STEADY_DETECT_EN
    logic [W-1:0] q_prev_q;
    logic         steady_q;

    // q_prev is only valid from the second RUN cycle, hence the gens_run guard.
    assign early_s = (state_q == RUN) && (gens_run != '0) && (engine_q == q_prev_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_prev_q <= '0;
            steady_q <= 1'b0;
        end else begin
            q_prev_q <= (state_q == RUN) ? engine_q : q_prev_q;
            if (cnt_clear_s) begin
                steady_q <= 1'b0;
            end else if (early_s && !abort) begin
                steady_q <= 1'b1;
            end else begin
                steady_q <= steady_q;
            end
        end
    end

    assign steady = steady_q;
`else
    assign early_s = 1'b0;
    assign steady  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            seed_q    <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            seed_q    <= seed_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        done_d      = 1'b0;
        aborted_d   = 1'b0;
        cnt_clear_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    seed_d      = seed;
                    cnt_clear_s = 1'b1;
                    state_d     = SEED;
                end else begin
                    state_d = IDLE;
                end
            end
            SEED: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = IDLE;
                end else if (tgt_zero_s) begin
                    state_d = OUT;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = IDLE;
                end else if (cnt_last_s || early_s) begin
                    state_d = OUT;
                end else begin
                    state_d = RUN;
                end
            end
            OUT: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = IDLE;
                end else if (result_ready) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The engine has no enable: outside RUN it is frozen by reloading its own row.
    always_comb begin
        engine_data = engine_q;
        case (state_q)
            SEED:    engine_data = seed_q;
            RUN:     engine_data = seed_q;
            default: engine_data = engine_q;
        endcase
    end

    assign engine_load  = (state_q != RUN);
    assign busy         = (state_q != IDLE);
    assign result_valid = (state_q == OUT);
    assign result       = (state_q == OUT) ? engine_q : '0;
    assign done         = done_q;
    assign aborted      = aborted_q;

endmodule
